// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong frame sequencer.
package pong_pkg;

    // Sequencer states; WAIT, SERVE and OVER are the idle states between frames.
    typedef enum logic [2:0] {
        ST_SERVE,
        ST_WAIT,
        ST_PADDLES,
        ST_BALL,
        ST_COLLIDE,
        ST_SCORE,
        ST_OVER
    } state_t;

    // Default screen and sprite geometry.
    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PAD_W        = 8;
    localparam int DEF_PAD_H        = 64;
    localparam int DEF_PAD_X1       = 16;
    localparam int DEF_PAD_X2       = 616;
    localparam int DEF_PAD_SPEED    = 4;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_SCORE_MAX    = 9;

    // On-screen coordinate as seen by the sprite logic.
    typedef logic [10:0] coord_t;
    // Signed working coordinate so the ball can step past an edge before it is clamped.
    typedef logic signed [11:0] pos_t;
    // Per-player score.
    typedef logic [3:0] score_t;

    // Increment that sticks at the winning score.
    function automatic score_t sat_inc(input score_t s, input score_t max);
        return (s >= max) ? max : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: registered top edge, stepped up or down once per strobe and
// clamped to the visible area.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int PAD_H     = DEF_PAD_H,
    parameter int PAD_SPEED = DEF_PAD_SPEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        up,
    input  logic        dn,
    output logic [10:0] y
);

    localparam coord_t Y_MAX = coord_t'(V_ACTIVE - PAD_H);
    localparam coord_t Y_RST = coord_t'((V_ACTIVE - PAD_H) / 2);
    localparam coord_t SPD   = coord_t'(PAD_SPEED);

    // Move one step per strobe; opposing buttons cancel, edges saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= Y_RST;
        end else if (step) begin
            if (up && !dn) begin
                y <= (y < SPD) ? '0 : y - SPD;
            end else if (dn && !up) begin
                y <= (y > Y_MAX - SPD) ? Y_MAX : y + SPD;
            end
        end
    end

endmodule

// File: rtl/pong_ctrl.sv
// Per-frame pong sequencer: once per frame_tick it steps both paddles,
// advances the ball, resolves wall/paddle collisions and keeps score.
// All position outputs are registers that only change during the short
// update burst that starts at the vblank tick.
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PAD_W        = DEF_PAD_W,
    parameter int PAD_H        = DEF_PAD_H,
    parameter int PAD_X1       = DEF_PAD_X1,
    parameter int PAD_X2       = DEF_PAD_X2,
    parameter int PAD_SPEED    = DEF_PAD_SPEED,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int SCORE_MAX    = DEF_SCORE_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        p1_up,
    input  logic        p1_dn,
    input  logic        p2_up,
    input  logic        p2_dn,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [10:0] pad1_y,
    output logic [10:0] pad2_y,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        game_over,
    output logic        busy
);

    // Geometry in the signed working domain so every compare is signed.
    localparam pos_t POS_ZERO = '0;
    localparam pos_t X_CTR    = pos_t'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam pos_t Y_CTR    = pos_t'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam pos_t X_MAX    = pos_t'(H_ACTIVE - BALL_SIZE);
    localparam pos_t Y_MAX    = pos_t'(V_ACTIVE - BALL_SIZE);
    localparam pos_t BS       = pos_t'(BALL_SIZE);
    localparam pos_t PH       = pos_t'(PAD_H);
    localparam pos_t P1_L     = pos_t'(PAD_X1);
    localparam pos_t P1_R     = pos_t'(PAD_X1 + PAD_W);
    localparam pos_t P2_L     = pos_t'(PAD_X2);
    localparam pos_t P2_R     = pos_t'(PAD_X2 + PAD_W);
    localparam pos_t P2_FACE  = pos_t'(PAD_X2 - BALL_SIZE);
    localparam pos_t SPD      = pos_t'(BALL_SPEED);

    localparam int                CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam score_t            S_MAX      = score_t'(SCORE_MAX);

    state_t           state;
    pos_t             bx, by;
    logic             dx_neg, dy_neg;
    logic [CNT_W-1:0] serve_cnt;
    logic             scorer2;     // last point went to player 2

    logic             pad_step;
    pos_t             pad1_s, pad2_s;
    pos_t             step_x, step_y;

    // Collision results for the ball position produced by the BALL state.
    pos_t             col_x, col_y;
    logic             col_dx_neg, col_dy_neg;
    logic             hit1, hit2, miss_p1, miss_p2;
    score_t           sc_new;

    // Paddles step on a serve tick or in the PADDLES state of a live frame.
    assign pad_step = (state == ST_PADDLES) || (state == ST_SERVE && frame_tick);

    pong_paddle #(
        .V_ACTIVE  (V_ACTIVE),
        .PAD_H     (PAD_H),
        .PAD_SPEED (PAD_SPEED)
    ) u_pad1 (
        .clk  (clk),
        .rst  (rst),
        .step (pad_step),
        .up   (p1_up),
        .dn   (p1_dn),
        .y    (pad1_y)
    );

    pong_paddle #(
        .V_ACTIVE  (V_ACTIVE),
        .PAD_H     (PAD_H),
        .PAD_SPEED (PAD_SPEED)
    ) u_pad2 (
        .clk  (clk),
        .rst  (rst),
        .step (pad_step),
        .up   (p2_up),
        .dn   (p2_dn),
        .y    (pad2_y)
    );

    assign pad1_s = pos_t'({1'b0, pad1_y});
    assign pad2_s = pos_t'({1'b0, pad2_y});
    assign step_x = dx_neg ? -SPD : SPD;
    assign step_y = dy_neg ? -SPD : SPD;

    assign ball_x = bx[10:0];
    assign ball_y = by[10:0];

    // Wall and paddle resolution; Y and X are independent so corners reflect both.
    always_comb begin
        col_x      = bx;
        col_y      = by;
        col_dx_neg = dx_neg;
        col_dy_neg = dy_neg;
        miss_p1    = 1'b0;
        miss_p2    = 1'b0;

        if (by <= POS_ZERO) begin
            col_y      = POS_ZERO;
            col_dy_neg = 1'b0;
        end else if (by >= Y_MAX) begin
            col_y      = Y_MAX;
            col_dy_neg = 1'b1;
        end

        hit1 = dx_neg && (bx <= P1_R) && (bx + BS > P1_L) &&
               (by + BS > pad1_s) && (by < pad1_s + PH);
        hit2 = !dx_neg && (bx + BS >= P2_L) && (bx < P2_R) &&
               (by + BS > pad2_s) && (by < pad2_s + PH);

        if (hit1) begin
            col_x      = P1_R;
            col_dx_neg = 1'b0;
        end else if (hit2) begin
            col_x      = P2_FACE;
            col_dx_neg = 1'b1;
        end else if (bx <= POS_ZERO) begin
            miss_p1 = 1'b1;
        end else if (bx >= X_MAX) begin
            miss_p2 = 1'b1;
        end
    end

    // Score that the SCORE state will commit for the player who won the point.
    always_comb begin
        sc_new = scorer2 ? sat_inc(score2, S_MAX) : sat_inc(score1, S_MAX);
    end

    // Frame sequencer with registered ball, score, busy and game_over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SERVE;
            bx        <= X_CTR;
            by        <= Y_CTR;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            serve_cnt <= CNT_RELOAD;
            scorer2   <= 1'b0;
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_SERVE: begin
                    if (frame_tick) begin
                        serve_cnt <= serve_cnt - CNT_ONE;
                        if (serve_cnt <= CNT_ONE) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (frame_tick) begin
                        state <= ST_PADDLES;
                        busy  <= 1'b1;
                    end
                end
                ST_PADDLES: begin
                    state <= ST_BALL;
                end
                ST_BALL: begin
                    bx    <= bx + step_x;
                    by    <= by + step_y;
                    state <= ST_COLLIDE;
                end
                ST_COLLIDE: begin
                    bx     <= col_x;
                    by     <= col_y;
                    dx_neg <= col_dx_neg;
                    dy_neg <= col_dy_neg;
                    if (miss_p1) begin
                        scorer2 <= 1'b1;
                        state   <= ST_SCORE;
                    end else if (miss_p2) begin
                        scorer2 <= 1'b0;
                        state   <= ST_SCORE;
                    end else begin
                        state <= ST_WAIT;
                        busy  <= 1'b0;
                    end
                end
                ST_SCORE: begin
                    busy <= 1'b0;
                    if (scorer2) begin
                        score2 <= sc_new;
                    end else begin
                        score1 <= sc_new;
                    end
                    if (sc_new == S_MAX) begin
                        game_over <= 1'b1;
                        state     <= ST_OVER;
                    end else begin
                        // Serve toward the player who just lost the point.
                        bx        <= X_CTR;
                        by        <= Y_CTR;
                        dx_neg    <= scorer2;
                        serve_cnt <= CNT_RELOAD;
                        state     <= ST_SERVE;
                    end
                end
                ST_OVER: begin
                    state <= ST_OVER;
                end
                default: begin
                    state <= ST_SERVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ctrl.sv
// Scoreboard bench for pong_ctrl: a frame-level game model predicts each
// tick's outcome, and a monitor checks the DUT around every tick.
module tb_pong_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        p1_up, p1_dn, p2_up, p2_dn;
    logic [10:0] ball_x, ball_y, pad1_y, pad2_y;
    logic [3:0]  score1, score2;
    logic        game_over, busy;

    always #5 clk = ~clk;

    pong_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .pad1_y     (pad1_y),
        .pad2_y     (pad2_y),
        .score1     (score1),
        .score2     (score2),
        .game_over  (game_over),
        .busy       (busy)
    );

    typedef struct {
        bit       play;
        int       p1_t2, p2_t2, bx_t2, by_t2, bx_t3, by_t3;
        bit [4:1] busy;
        int       bx, by, p1, p2, s1, s2;
        bit       over;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level game model ----------------
    localparam int M_SERVE = 0, M_PLAY = 1, M_OVER = 2;
    int m_mode, m_cnt, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2;

    task automatic model_reset();
        m_mode = M_SERVE; m_cnt = 60;
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_p1 = 208; m_p2 = 208; m_s1 = 0; m_s2 = 0;
    endtask

    function automatic int step_pad(input int y, input bit u, input bit d);
        if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
        if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2,
                              output exp_t e);
        int nx, ny;
        bit h1, h2;
        e = '{default: 0};
        if (m_mode != M_OVER) begin
            m_p1 = step_pad(m_p1, u1, d1);
            m_p2 = step_pad(m_p2, u2, d2);
            if (m_mode == M_SERVE) begin
                m_cnt--;
                if (m_cnt == 0) m_mode = M_PLAY;
            end else begin
                e.play = 1;
                e.p1_t2 = m_p1; e.p2_t2 = m_p2;
                e.bx_t2 = m_bx; e.by_t2 = m_by;
                nx = m_bx + 2 * m_dx;
                ny = m_by + 2 * m_dy;
                e.bx_t3 = nx & 2047; e.by_t3 = ny & 2047;
                e.busy = 4'b0111;
                m_bx = nx; m_by = ny;
                if (ny <= 0) begin m_by = 0; m_dy = 1; end
                else if (ny >= 472) begin m_by = 472; m_dy = -1; end
                h1 = (m_dx < 0) && (nx <= 24) && (nx + 8 > 16) && (ny + 8 > m_p1) && (ny < m_p1 + 64);
                h2 = (m_dx > 0) && (nx + 8 >= 616) && (nx < 624) && (ny + 8 > m_p2) && (ny < m_p2 + 64);
                if (h1) begin
                    m_bx = 24; m_dx = 1;
                end else if (h2) begin
                    m_bx = 608; m_dx = -1;
                end else if (nx <= 0 || nx >= 632) begin
                    e.busy[4] = 1;
                    if (nx <= 0) m_s2++; else m_s1++;
                    if (m_s1 == 9 || m_s2 == 9) begin
                        m_mode = M_OVER;
                    end else begin
                        m_dx = (nx <= 0) ? -1 : 1;
                        m_bx = 316; m_by = 236; m_cnt = 60; m_mode = M_SERVE;
                    end
                end
            end
        end
        e.bx = m_bx & 2047; e.by = m_by & 2047;
        e.p1 = m_p1; e.p2 = m_p2; e.s1 = m_s1; e.s2 = m_s2;
        e.over = (m_mode == M_OVER);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    bit   mon_have;

    always @(posedge clk) begin
        if (frame_tick && !rst) begin
            mon_have = (q.size() > 0);
            if (mon_have) begin
                mon_e = q.pop_front();
            end else begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: got 0 expected entries, required 1");
            end
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (mon_have) begin
                    if (k <= 4) check($sformatf("busy_t%0d", k), int'(busy), int'(mon_e.busy[k]));
                    if (k == 5) check("busy_t5", int'(busy), 0);
                    if (k == 2 && mon_e.play) begin
                        check("pad1_t2", int'(pad1_y), mon_e.p1_t2);
                        check("pad2_t2", int'(pad2_y), mon_e.p2_t2);
                        check("ball_x_t2", int'(ball_x), mon_e.bx_t2);
                        check("ball_y_t2", int'(ball_y), mon_e.by_t2);
                    end
                    if (k == 3 && mon_e.play) begin
                        check("ball_x_t3", int'(ball_x), mon_e.bx_t3);
                        check("ball_y_t3", int'(ball_y), mon_e.by_t3);
                    end
                    if (k == 6) begin
                        check("ball_x", int'(ball_x), mon_e.bx);
                        check("ball_y", int'(ball_y), mon_e.by);
                        check("pad1_y", int'(pad1_y), mon_e.p1);
                        check("pad2_y", int'(pad2_y), mon_e.p2);
                        check("score1", int'(score1), mon_e.s1);
                        check("score2", int'(score2), mon_e.s2);
                        check("game_over", int'(game_over), int'(mon_e.over));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2);
        exp_t e;
        @(negedge clk);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        model_tick(u1, d1, u2, d2, e);
        q.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ball_x"}, int'(ball_x), 316);
        check({tag, "_ball_y"}, int'(ball_y), 236);
        check({tag, "_pad1_y"}, int'(pad1_y), 208);
        check({tag, "_pad2_y"}, int'(pad2_y), 208);
        check({tag, "_score1"}, int'(score1), 0);
        check({tag, "_score2"}, int'(score2), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Steer a paddle toward the ball most of the time, otherwise mash buttons.
    task automatic pick(input int p, output bit u, output bit d);
        u = 0; d = 0;
        if ($urandom_range(0, 9) < 8) begin
            if (p + 32 < m_by + 2) d = 1;
            else if (p + 32 > m_by + 6) u = 1;
        end else begin
            u = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        exp_t e;
        bit u1, d1, u2, d2;
        rst = 1'b1; frame_tick = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        // Serve period with p1_up held: ball parked, paddle 1 walks to the top.
        for (int i = 0; i < 60; i++) do_tick(1, 0, 0, 0);
        // Both buttons on each paddle: no movement while the ball starts moving.
        for (int i = 0; i < 5; i++) do_tick(1, 1, 1, 1);
        // Rally with paddles mostly tracking the ball.
        for (int i = 0; i < 600 && m_mode != M_OVER; i++) begin
            pick(m_p1, u1, d1);
            pick(m_p2, u2, d2);
            do_tick(u1, d1, u2, d2);
        end
        // Random buttons until somebody wins.
        for (int i = 0; i < 6000 && m_mode != M_OVER; i++)
            do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("game_over_reached", int'(game_over), 1);
        // Game over: ticks and buttons must change nothing.
        for (int i = 0; i < 5; i++)
            do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset("rst1");
        rst = 1'b0;

        for (int i = 0; i < 60; i++) do_tick(0, 0, 0, 0);

        // Reset lands in the middle of a live frame update.
        @(negedge clk);
        p1_up = 1'b0; p1_dn = 1'b1; p2_up = 1'b0; p2_dn = 1'b0;
        model_tick(0, 1, 0, 0, e);
        e.busy = 4'b0011;
        e.bx_t3 = 316; e.by_t3 = 236;
        e.bx = 316; e.by = 236; e.p1 = 208; e.p2 = 208;
        e.s1 = 0; e.s2 = 0; e.over = 0;
        model_reset();
        q.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Back in SERVE: the ball must stay parked.
        for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 1);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
